ibuf_write_sequencer: RTL and testbench

Parametrised successor to the input-buffer write-address generator. It accepts a DRAM read stream with a valid/ready handshake and emits each word with its buffer bank, row, channel and column address. Rows map as follows: STRIDE consecutive rows go to one bank, then the next bank, over POY banks; the row base then advances by STRIDE and wraps at DEPTH. It adds multi-channel interleave, output backpressure, runtime frame length and a done pulse. It sits between the DMA read port and the input line-buffer banks.

---
 rtl/ibuf_write_sequencer.sv | 130 +++++++++++++
 tb/tb_ibuf_write_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ibuf_write_sequencer.sv
// Input-buffer write sequencer: tags each accepted DRAM word with bank/row/channel/column
// and forwards it through a single no-bubble output register with a per-frame done pulse.
module ibuf_write_sequencer #(
  parameter int DW     = 32,
  parameter int STRIDE = 1,
  parameter int BURST  = 32,
  parameter int CH     = 1,
  parameter int POY    = 3,
  parameter int DEPTH  = 2 * STRIDE,
  localparam int BW    = (POY > 1)    ? $clog2(POY)    : 1,
  localparam int RW    = (DEPTH > 1)  ? $clog2(DEPTH)  : 1,
  localparam int CHW   = (CH > 1)     ? $clog2(CH)     : 1,
  localparam int CW    = (BURST > 1)  ? $clog2(BURST)  : 1,
  localparam int SW    = (STRIDE > 1) ? $clog2(STRIDE) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [15:0]    cfg_rows,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [DW-1:0]  s_data,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [DW-1:0]  m_data,
  output logic [BW-1:0]  m_bank,
  output logic [RW-1:0]  m_row,
  output logic [CHW-1:0] m_ch,
  output logic [CW-1:0]  m_col,
  output logic           m_last,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   col;
  logic [CHW-1:0]  ch;
  logic [SW-1:0]   bias;
  logic [BW-1:0]   bank;
  logic [RW-1:0]   base;
  logic [15:0]     row_cnt;
  logic [15:0]     rows_cfg;

  logic accept, col_wrap, ch_wrap, bias_wrap, bank_wrap, last_word;

  // Row base steps by STRIDE and wraps once the last bank group of DEPTH is used.
  function automatic logic [RW-1:0] next_base(input logic [RW-1:0] b);
    if (b == RW'(DEPTH - STRIDE))
      next_base = '0;
    else
      next_base = b + RW'(STRIDE);
  endfunction

  assign s_ready   = (state == RUN) && (!m_valid || m_ready);
  assign accept    = s_valid && s_ready;
  assign busy      = (state == RUN) || (state == DRAIN);

  assign col_wrap  = (col == CW'(BURST - 1));
  assign ch_wrap   = col_wrap && (ch == CHW'(CH - 1));
  assign bias_wrap = ch_wrap && (bias == SW'(STRIDE - 1));
  assign bank_wrap = bias_wrap && (bank == BW'(POY - 1));
  assign last_word = ch_wrap && (row_cnt == rows_cfg - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      col      <= '0;
      ch       <= '0;
      bias     <= '0;
      bank     <= '0;
      base     <= '0;
      row_cnt  <= '0;
      rows_cfg <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_data   <= '0;
      m_bank   <= '0;
      m_row    <= '0;
      m_ch     <= '0;
      m_col    <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rows_cfg <= cfg_rows;
            col      <= '0;
            ch       <= '0;
            bias     <= '0;
            bank     <= '0;
            base     <= '0;
            row_cnt  <= '0;
            state    <= (cfg_rows == 16'd0) ? DONE : RUN;
          end
        end
        RUN:   if (accept && last_word) state <= DRAIN;
        DRAIN: if (m_valid && m_ready) state <= DONE;
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Output register: load on accept, otherwise drop once the word is taken.
      if (accept) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
        m_bank  <= bank;
        m_row   <= base + RW'(bias);
        m_ch    <= ch;
        m_col   <= col;
        m_last  <= last_word;
        col     <= col_wrap  ? '0 : col + CW'(1);
        if (col_wrap)  ch      <= ch_wrap   ? '0 : ch + CHW'(1);
        if (ch_wrap)   row_cnt <= row_cnt + 16'd1;
        if (ch_wrap)   bias    <= bias_wrap ? '0 : bias + SW'(1);
        if (bias_wrap) bank    <= bank_wrap ? '0 : bank + BW'(1);
        if (bank_wrap) base    <= next_base(base);
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ibuf_write_sequencer.sv
// Directed bench for ibuf_write_sequencer with STRIDE=2, BURST=4, CH=2, POY=3, DEPTH=4.
module tb_ibuf_write_sequencer;

  localparam int DW = 32, STRIDE = 2, BURST = 4, CH = 2, POY = 3, DEPTH = 4;
  localparam int WPR = BURST * CH;

  logic          clk = 1'b0;
  logic          rst, start, s_valid, s_ready, m_valid, m_ready, m_last, busy, done;
  logic [15:0]   cfg_rows;
  logic [DW-1:0] s_data, m_data;
  logic [1:0]    m_bank, m_row, m_col;
  logic [0:0]    m_ch;

  int n_chk = 0;
  int n_bad = 0;

  ibuf_write_sequencer #(
    .DW(DW), .STRIDE(STRIDE), .BURST(BURST), .CH(CH), .POY(POY), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_bank(m_bank), .m_row(m_row), .m_ch(m_ch), .m_col(m_col),
    .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Packed {bank,row,ch,col} for output word n, derived from the row mapping.
  function automatic logic [31:0] exp_addr(input int n);
    int col, ch, bias, bank, base;
    col  = n % BURST;
    ch   = (n / BURST) % CH;
    bias = (n / WPR) % STRIDE;
    bank = (n / (WPR * STRIDE)) % POY;
    base = ((n / (WPR * STRIDE * POY)) % (DEPTH / STRIDE)) * STRIDE;
    exp_addr = 32'((bank << 5) | ((base + bias) << 3) | (ch << 2) | col);
  endfunction

  function automatic logic [31:0] cur_addr();
    cur_addr = 32'({m_bank, m_row, m_ch, m_col});
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_mvalid"}, 32'(m_valid), 32'd0);
    check({tag, "_busy"},   32'(busy),    32'd0);
    check({tag, "_sready"}, 32'(s_ready), 32'd0);
    check({tag, "_addr"},   cur_addr(),   32'd0);
    check({tag, "_data"},   m_data,       32'd0);
    check({tag, "_last"},   32'(m_last),  32'd0);
    check({tag, "_done"},   32'(done),    32'd0);
  endtask

  // Runs one frame; optional gaps, one 5-cycle stall at word stall_at,
  // a stray start at iteration restart_at, or a reset at iteration rst_at.
  task automatic run_frame(input string tag, input int rows, input bit gaps,
                           input int stall_at, input int restart_at, input int rst_at);
    int total, sent, rcvd, stall, last_it, done_it, it, chk_it;
    bit stalled_once;
    logic [31:0] held_data, held_addr;
    total = rows * WPR;
    sent = 0; rcvd = 0; stall = 0; last_it = -1; done_it = -1; it = 0; chk_it = -1;
    stalled_once = 0; held_data = '0; held_addr = '0;
    start = 1'b1; cfg_rows = 16'(rows);
    @(posedge clk); #1;
    start = 1'b0;
    while (done_it < 0 && it < 2000) begin
      s_valid  = gaps ? ((it % 2) == 0) : 1'b1;
      s_data   = 32'hA500_0000 + 32'(sent);
      start    = (it == restart_at);
      cfg_rows = (it == restart_at) ? 16'd1 : 16'(rows);
      rst      = (it == rst_at);
      if (stall_at >= 0 && !stalled_once && m_valid && rcvd == stall_at) begin
        stall = 5; stalled_once = 1; held_data = m_data; held_addr = cur_addr();
      end
      m_ready = (stall == 0);
      #1;
      if (rst) begin
        @(posedge clk); #1;
        rst = 1'b0; s_valid = 1'b0;
        check_idle({tag, "_midrst"});
        return;
      end
      if (stall > 0) begin
        check({tag, "_stall_data"},   m_data,          held_data);
        check({tag, "_stall_addr"},   cur_addr(),      held_addr);
        check({tag, "_stall_sready"}, 32'(s_ready),    32'd0);
        stall--;
        if (stall == 0) chk_it = it + 2;
      end
      if (it == chk_it) begin
        check({tag, "_resume_valid"}, 32'(m_valid), 32'd1);
        check({tag, "_resume_data"},  m_data, 32'hA500_0000 + 32'(stall_at + 1));
      end
      if (m_valid && m_ready) begin
        check({tag, "_data"}, m_data,      32'hA500_0000 + 32'(rcvd));
        check({tag, "_addr"}, cur_addr(),  exp_addr(rcvd));
        check({tag, "_last"}, 32'(m_last), 32'(rcvd == total - 1));
        if (m_last) last_it = it;
        rcvd++;
      end
      if (done) done_it = it;
      if (s_valid && s_ready) sent++;
      @(posedge clk); #1;
      it++;
    end
    check({tag, "_done_seen"},  32'(done_it >= 0),  32'd1);
    check({tag, "_done_delay"}, 32'(done_it - last_it), 32'd2);
    check({tag, "_words_out"},  32'(rcvd), 32'(total));
    check({tag, "_words_in"},   32'(sent), 32'(total));
    #1;
    check({tag, "_post_done"},   32'(done),    32'd0);
    check({tag, "_post_sready"}, 32'(s_ready), 32'd0);
    check({tag, "_post_busy"},   32'(busy),    32'd0);
    s_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_rows = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame("midrst", 14, 1'b0, -1, -1, 20);
    run_frame("restart", 1, 1'b0, -1, -1, -1);
    run_frame("walk", 14, 1'b0, -1, -1, -1);
    run_frame("bp", 3, 1'b0, 10, -1, -1);
    run_frame("gaps", 3, 1'b1, -1, -1, -1);
    run_frame("ignstart", 3, 1'b0, -1, 5, -1);

    // Zero-row frame goes straight to DONE without emitting any word.
    @(posedge clk); #1;
    start = 1'b1; cfg_rows = 16'd0; s_valid = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_done_c1",   32'(done),    32'd0);
    check("zero_sready_c1", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    check("zero_done_c2",   32'(done),    32'd1);
    check("zero_mvalid_c2", 32'(m_valid), 32'd0);
    @(posedge clk); #1;
    check("zero_done_c3",   32'(done),    32'd0);
    check("zero_mvalid_c3", 32'(m_valid), 32'd0);
    s_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
